// File: rtl/fp32_pkg.sv
// Shared FP32 field constants used by operand classification and the scheduler.
package fp32_pkg;

    localparam int          EXP_MSB      = 30;
    localparam int          EXP_LSB      = 23;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

    typedef logic [31:0] fp32_t;

endpackage

// File: rtl/fp32_operand_classify.sv
// Combinational operand classifier: flags a +0 operand and an all-ones
// exponent (infinity or NaN) on either input of the multiplication.
module fp32_operand_classify
    import fp32_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  zero,
    output logic  inf
);

    // Only the exact all-zero pattern counts as zero; -0 deliberately does not.
    assign zero = (a == FP32_ZERO) || (b == FP32_ZERO);
    assign inf  = (a[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) ||
                  (b[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);

endmodule

// File: rtl/fp32_mul_scheduler.sv
// Round-robin scheduler sharing one external pipelined FP32 multiplier among
// NUM_REQ requesters. Accepted operands are issued on the edge after grant;
// a sideband pipe matched to MUL_LATENCY tags each returning product with
// requester id and operand-class flags.
module fp32_mul_scheduler
    import fp32_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MUL_LATENCY = 3,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 mul_valid,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_result,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_inf,
    output logic                 busy
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            zero;
        logic            inf;
    } side_t;

    fp32_t           op_a_arr [NUM_REQ];
    fp32_t           op_b_arr [NUM_REQ];
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    fp32_t           sel_a;
    fp32_t           sel_b;
    logic            sel_zero;
    logic            sel_inf;
    side_t           issue_q;
    fp32_t           mul_a_q;
    fp32_t           mul_b_q;
    side_t           side_q [MUL_LATENCY];
    side_t           tail;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a_arr[g] = req_a[32*g +: 32];
        assign op_b_arr[g] = req_b[32*g +: 32];
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = grant_found && enable && rstn;
    assign sel_a  = op_a_arr[grant_idx];
    assign sel_b  = op_b_arr[grant_idx];

    // One-hot accept strobe, suppressed while disabled or held in reset.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    fp32_operand_classify u_classify (
        .a    (sel_a),
        .b    (sel_b),
        .zero (sel_zero),
        .inf  (sel_inf)
    );

    // Issue stage: register the granted operands and advance the RR pointer.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) begin
            last_q  <= ID_W'(NUM_REQ - 1);
            issue_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            issue_q.valid <= accept;
            if (accept) begin
                last_q       <= grant_idx;
                issue_q.id   <= grant_idx;
                issue_q.zero <= sel_zero;
                issue_q.inf  <= sel_inf;
                mul_a_q      <= sel_a;
                mul_b_q      <= sel_b;
            end
        end
    end

    // Sideband pipe that tracks each issued operation through the multiplier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this small array is reset on purpose so reset kills in-flight operations.
            for (int i = 0; i < MUL_LATENCY; i++) side_q[i] <= '0;
        end else begin
            side_q[0] <= issue_q.valid ? issue_q : '0;
            for (int i = 1; i < MUL_LATENCY; i++) side_q[i] <= side_q[i-1];
        end
    end

    // Busy while anything sits on the issue bus or inside the sideband pipe.
    always_comb begin
        busy = issue_q.valid;
        for (int i = 0; i < MUL_LATENCY; i++) busy = busy | side_q[i].valid;
    end

    assign tail      = side_q[MUL_LATENCY-1];
    assign mul_valid = issue_q.valid;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = tail.valid;
    assign rsp_id    = tail.id;
    assign rsp_zero  = tail.zero;
    assign rsp_inf   = tail.inf;
    // A zero operand with no inf/NaN partner short-circuits to +0.
    assign rsp_data  = (tail.zero && !tail.inf) ? FP32_ZERO : mul_result;

endmodule

// File: tb/tb_fp32_mul_scheduler.sv
// Self-checking bench for fp32_mul_scheduler: directed scenarios plus random
// traffic, checked against a transaction-level reference model (round-robin
// pick, expected-response queue with due cycles) and a stub multiplier.
module tb_fp32_mul_scheduler;

    localparam int N = 4;
    localparam int L = 3;

    logic           clk;
    logic           rstn;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           mul_valid;
    logic [31:0]    mul_a;
    logic [31:0]    mul_b;
    logic [31:0]    mul_result;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_data;
    logic           rsp_zero;
    logic           rsp_inf;
    logic           busy;

    fp32_mul_scheduler #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_inf    (rsp_inf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier: known products for the directed cases, a fixed scramble otherwise.
    function automatic logic [31:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (a == 32'h0000_0000 && b == 32'h3F80_0000) return 32'hDEAD_BEEF;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= mul_valid ? stub_mul(mul_a, mul_b) : 32'h0;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[L-1];

    typedef struct {
        int          due;
        int          id;
        logic        zero;
        logic        inf;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rr_last = N - 1;
    logic        prev_v = 1'b0;
    logic [31:0] prev_a, prev_b;
    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    int          obs_grant;
    int          last_acc_cyc = 0;
    int          last_rsp_cyc = -1;
    logic [31:0] last_rsp_data;
    int          last_rsp_id;
    logic        last_rsp_zero, last_rsp_inf;
    int          acc_cyc, rst_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive at negedge, check 1 ns later, then advance the model.
    task automatic cycle(input logic [N-1:0] v, input logic en, input logic rst);
        int          gid;
        int          idx;
        logic [N-1:0] exp_ready;
        exp_t        e;
        @(negedge clk);
        req_valid = v;
        enable    = en;
        rstn      = rst;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
        #1;
        cyc++;
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
        if (!rst) begin
            exp_q.delete();
            rr_last = N - 1;
            prev_v  = 1'b0;
            check("rst_req_ready", {28'h0, req_ready}, 32'h0);
            check("rst_mul_valid", {31'h0, mul_valid}, 32'h0);
            check("rst_mul_a", mul_a, 32'h0);
            check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
            return;
        end
        gid = -1;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                idx = (rr_last + k) % N;
                if (gid < 0 && v[idx]) gid = idx;
            end
        end
        exp_ready = '0;
        if (gid >= 0) exp_ready[gid] = 1'b1;
        check("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
        check("mul_valid", {31'h0, mul_valid}, {31'h0, prev_v});
        if (prev_v) begin
            check("mul_a", mul_a, prev_a);
            check("mul_b", mul_b, prev_b);
        end
        check("busy", {31'h0, busy}, {31'h0, (exp_q.size() != 0)});
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("rsp_id", {30'h0, rsp_id}, e.id);
            check("rsp_zero", {31'h0, rsp_zero}, {31'h0, e.zero});
            check("rsp_inf", {31'h0, rsp_inf}, {31'h0, e.inf});
            check("rsp_data", rsp_data, e.data);
        end else begin
            check("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
        end
        if (rsp_valid) begin
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_data;
            last_rsp_id   = int'(rsp_id);
            last_rsp_zero = rsp_zero;
            last_rsp_inf  = rsp_inf;
        end
        prev_v = (gid >= 0);
        if (gid >= 0) begin
            prev_a = op_a[gid];
            prev_b = op_b[gid];
            e.due  = cyc + 1 + L;
            e.id   = gid;
            e.zero = (op_a[gid] == 32'h0) || (op_b[gid] == 32'h0);
            e.inf  = (prev_a[30:23] == 8'hFF) || (prev_b[30:23] == 8'hFF);
            e.data = (e.zero && !e.inf) ? 32'h0 : stub_mul(op_a[gid], op_b[gid]);
            exp_q.push_back(e);
            rr_last      = gid;
            last_acc_cyc = cyc;
        end
    endtask

    task automatic drain();
        repeat (L + 3) cycle('0, 1'b1, 1'b1);
        check("drained_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        enable = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 32'h0;
            op_b[i] = 32'h0;
        end

        // Reset state, then release.
        cycle('0, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b1);

        // Fairness: all four requesting for 8 cycles.
        for (int i = 0; i < N; i++) begin
            op_a[i] = 32'h3F80_0000 + i;
            op_b[i] = 32'h4000_0000 + (i << 4);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1, 1'b1);
            check("fair_order", obs_grant, i % 4);
        end
        drain();

        // Single operation: 2.0 * 3.0.
        op_a[0] = 32'h4000_0000;
        op_b[0] = 32'h4040_0000;
        cycle(4'b0001, 1'b1, 1'b1);
        check("single_grant", obs_grant, 0);
        acc_cyc = last_acc_cyc;
        drain();
        check("single_latency", last_rsp_cyc - acc_cyc, 4);
        check("single_data", last_rsp_data, 32'h40C0_0000);
        check("single_id", last_rsp_id, 0);
        check("single_flags", {30'h0, last_rsp_zero, last_rsp_inf}, 32'h0);

        // Zero bypass.
        op_a[1] = 32'h0000_0000;
        op_b[1] = 32'h3F80_0000;
        cycle(4'b0010, 1'b1, 1'b1);
        drain();
        check("zero_flags", {30'h0, last_rsp_zero, last_rsp_inf}, 32'h2);
        check("zero_data", last_rsp_data, 32'h0);

        // Inf with zero partner keeps the multiplier result.
        op_a[2] = 32'h7F80_0000;
        op_b[2] = 32'h0000_0000;
        cycle(4'b0100, 1'b1, 1'b1);
        drain();
        check("inf_flags", {30'h0, last_rsp_zero, last_rsp_inf}, 32'h3);
        check("inf_data", last_rsp_data, stub_mul(32'h7F80_0000, 32'h0));

        // Enable low with pending requests: no grants, in-flight op drains.
        cycle(4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < L + 3; i++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            check("disabled_no_grant", obs_grant, -1);
        end
        check("disabled_busy", {31'h0, busy}, 32'h0);

        // Reset two cycles after an accept kills the operation.
        cycle(4'b1000, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1);
        cycle(4'b1111, 1'b1, 1'b0);
        rst_cyc = cyc;
        cycle('0, 1'b1, 1'b1);
        drain();
        check("no_rsp_after_rst", {31'h0, (last_rsp_cyc < rst_cyc)}, 32'h1);
        cycle(4'b1111, 1'b1, 1'b1);
        check("post_rst_grant", obs_grant, 0);
        drain();

        // Random traffic with occasional enable drops and withdrawn requests.
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = rand_op();
                op_b[i] = rand_op();
            end
            cycle(4'($urandom), ($urandom_range(0, 7) != 0), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
